// File: rtl/bus_datapath_p.sv
// bus_datapath_p
// Parametrised single-bus processor datapath. It holds the register file and the
// PC, IR, Y, Z, HI, LO, MAR and MDR registers, an ALU, and an iterative signed
// multiply/divide unit.
//
// Ports:
//   clk, clr            rising-edge clock, asynchronous active-high clear
//   reg_in/reg_out      per-register load / bus-drive strobes
//   pc_in/pc_out/inc_pc PC load, drive and increment
//   *_in / *_out        load and bus-drive strobes for the special registers
//   z_in                capture the single-cycle ALU result into Z
//   mdr_in, read        MDR load: read=1 takes mdatain (when mem_rdy), read=0 takes bus
//   mem_rdy, mdatain    memory read handshake and data
//   c_value, c_out      immediate constant onto the bus
//   alu_op, alu_start   ALU operation code and MUL/DIV start
//   alu_busy, alu_done  MUL/DIV running / one-cycle completion pulse
//   div0                the last DIV had a zero divisor
//   mdr_wait            MDR load stalled on mem_rdy
//   bus_err             more than one bus driver is active
//   bus, ir_q, mar_q, pc_q  observed bus and register contents
//
// MUL/DIV sequencer:
//   state  | meaning
//   S_IDLE | waiting for alu_start with op MUL or DIV
//   S_RUN  | WIDTH iteration cycles, alu_busy=1
//   S_DONE | Z holds the result, alu_done=1 for one cycle
module bus_datapath_p #(
    parameter int WIDTH = 32,
    parameter int NREGS = 16,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [NREGS-1:0] reg_in,
    input  logic [NREGS-1:0] reg_out,
    input  logic             pc_in,
    input  logic             pc_out,
    input  logic             inc_pc,
    input  logic             ir_in,
    input  logic             y_in,
    input  logic             mar_in,
    input  logic             hi_in,
    input  logic             lo_in,
    input  logic             hi_out,
    input  logic             lo_out,
    input  logic             zhi_out,
    input  logic             zlo_out,
    input  logic             mdr_out,
    input  logic             c_out,
    input  logic             z_in,
    input  logic             mdr_in,
    input  logic             read,
    input  logic             mem_rdy,
    input  logic [WIDTH-1:0] mdatain,
    input  logic [WIDTH-1:0] c_value,
    input  logic [3:0]       alu_op,
    input  logic             alu_start,
    output logic             alu_busy,
    output logic             alu_done,
    output logic             div0,
    output logic             mdr_wait,
    output logic             bus_err,
    output logic [WIDTH-1:0] bus,
    output logic [WIDTH-1:0] ir_q,
    output logic [WIDTH-1:0] mar_q,
    output logic [WIDTH-1:0] pc_q
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} md_state_t;

    localparam int ND = NREGS + 7;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_SHR  = 4'd4;
    localparam logic [3:0] OP_SHRA = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_ROR  = 4'd7;
    localparam logic [3:0] OP_ROL  = 4'd8;
    localparam logic [3:0] OP_NEG  = 4'd9;
    localparam logic [3:0] OP_NOT  = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;
    localparam logic [3:0] OP_DIV  = 4'd12;

    logic [WIDTH-1:0] r_q [NREGS];
    logic [WIDTH-1:0] y_q, hi_q, lo_q, mdr_q, zhi_q, zlo_q;

    // ---------------- bus ----------------
    logic [ND-1:0]    drv;
    logic             multi;
    logic [WIDTH-1:0] bus_or;

    assign drv   = {reg_out, pc_out, hi_out, lo_out, zhi_out, zlo_out, mdr_out, c_out};
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi = |(drv & (drv - ND'(1)));

    always_comb begin
        bus_or = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (reg_out[i]) bus_or = bus_or | r_q[i];
        end
        if (pc_out)  bus_or = bus_or | pc_q;
        if (hi_out)  bus_or = bus_or | hi_q;
        if (lo_out)  bus_or = bus_or | lo_q;
        if (zhi_out) bus_or = bus_or | zhi_q;
        if (zlo_out) bus_or = bus_or | zlo_q;
        if (mdr_out) bus_or = bus_or | mdr_q;
        if (c_out)   bus_or = bus_or | c_value;
    end

    assign bus      = multi ? '0 : bus_or;
    assign bus_err  = multi;
    assign mdr_wait = mdr_in & read & ~mem_rdy;

    // ---------------- single-cycle ALU ----------------
    logic [SHW-1:0]     shamt;
    logic [2*WIDTH-1:0] rot_r, rot_l;
    logic [WIDTH-1:0]   alu_res;

    assign shamt = bus[SHW-1:0];
    assign rot_r = {y_q, y_q} >> shamt;
    assign rot_l = {y_q, y_q} << shamt;

    always_comb begin
        alu_res = '0;
        case (alu_op)
            OP_ADD:  alu_res = y_q + bus;
            OP_SUB:  alu_res = y_q - bus;
            OP_AND:  alu_res = y_q & bus;
            OP_OR:   alu_res = y_q | bus;
            OP_SHR:  alu_res = y_q >> shamt;
            OP_SHRA: alu_res = $signed(y_q) >>> shamt;
            OP_SHL:  alu_res = y_q << shamt;
            OP_ROR:  alu_res = rot_r[WIDTH-1:0];
            OP_ROL:  alu_res = rot_l[2*WIDTH-1:WIDTH];
            OP_NEG:  alu_res = -bus;
            OP_NOT:  alu_res = ~bus;
            default: alu_res = '0;
        endcase
    end

    // ---------------- MUL/DIV sequencer ----------------
    md_state_t        md_state, md_next;
    logic             md_div, neg_a, neg_b, b_zero;
    logic [WIDTH-1:0] mag_a, mag_b, acc_hi, acc_lo;
    logic [SHW-1:0]   cnt;
    logic             start_ok;
    logic [WIDTH-1:0] a_mag_in, b_mag_in;

    assign start_ok = (md_state == S_IDLE) && alu_start &&
                      ((alu_op == OP_MUL) || (alu_op == OP_DIV));
    assign a_mag_in = y_q[WIDTH-1] ? -y_q : y_q;
    assign b_mag_in = bus[WIDTH-1] ? -bus : bus;
    assign alu_busy = (md_state == S_RUN);
    assign alu_done = (md_state == S_DONE);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) md_state <= S_IDLE;
        else     md_state <= md_next;
    end

    always_comb begin
        md_next = md_state;
        case (md_state)
            S_IDLE:  if (start_ok) md_next = S_RUN;
            S_RUN:   if (cnt == '0) md_next = S_DONE;
            S_DONE:  md_next = S_IDLE;
            default: md_next = S_IDLE;
        endcase
    end

    // One iteration step. MUL: shift-add with the product building in acc_hi:acc_lo.
    // DIV: restoring division, remainder in acc_hi, dividend shifting out of acc_lo
    // while quotient bits shift in.
    logic [WIDTH:0]     mul_sum, div_sh, div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   step_hi, step_lo;
    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH-1:0]   quo_s, rem_s, dividend;

    assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_a} : '0);
    assign div_sh   = {acc_hi, acc_lo[WIDTH-1]};
    assign div_diff = div_sh - {1'b0, mag_b};
    assign div_ge   = (div_sh >= {1'b0, mag_b});

    always_comb begin
        if (md_div) begin
            step_hi = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], div_ge};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    assign prod     = {step_hi, step_lo};
    assign prod_s   = (neg_a ^ neg_b) ? -prod : prod;
    assign quo_s    = (neg_a ^ neg_b) ? -step_lo : step_lo;
    assign rem_s    = neg_a ? -step_hi : step_hi;
    assign dividend = neg_a ? -mag_a : mag_a;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            md_div <= 1'b0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            b_zero <= 1'b0;
            mag_a  <= '0;
            mag_b  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            cnt    <= '0;
            div0   <= 1'b0;
            zhi_q  <= '0;
            zlo_q  <= '0;
        end else begin
            if (start_ok) begin
                md_div <= (alu_op == OP_DIV);
                neg_a  <= y_q[WIDTH-1];
                neg_b  <= bus[WIDTH-1];
                b_zero <= (bus == '0);
                mag_a  <= a_mag_in;
                mag_b  <= b_mag_in;
                acc_hi <= '0;
                acc_lo <= (alu_op == OP_DIV) ? a_mag_in : b_mag_in;
                cnt    <= SHW'(WIDTH - 1);
                if (alu_op == OP_DIV) div0 <= (bus == '0);
            end
            if (md_state == S_RUN) begin
                acc_hi <= step_hi;
                acc_lo <= step_lo;
                cnt    <= cnt - SHW'(1);
                if (cnt == '0) begin
                    if (!md_div) begin
                        zhi_q <= prod_s[2*WIDTH-1:WIDTH];
                        zlo_q <= prod_s[WIDTH-1:0];
                    end else if (b_zero) begin
                        zhi_q <= dividend;
                        zlo_q <= '1;
                    end else begin
                        zhi_q <= rem_s;
                        zlo_q <= quo_s;
                    end
                end
            end else if (z_in) begin
                zhi_q <= '0;
                zlo_q <= alu_res;
            end
        end
    end

    // ---------------- register loads ----------------
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < NREGS; i++) r_q[i] <= '0;
            pc_q  <= '0;
            ir_q  <= '0;
            y_q   <= '0;
            mar_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            mdr_q <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (reg_in[i]) r_q[i] <= bus;
            end
            if (pc_in)       pc_q <= bus;
            else if (inc_pc) pc_q <= pc_q + WIDTH'(1);
            if (ir_in)  ir_q  <= bus;
            if (y_in)   y_q   <= bus;
            if (mar_in) mar_q <= bus;
            if (hi_in)  hi_q  <= bus;
            if (lo_in)  lo_q  <= bus;
            if (mdr_in) begin
                if (!read)        mdr_q <= bus;
                else if (mem_rdy) mdr_q <= mdatain;
            end
        end
    end

endmodule

// File: tb/tb_bus_datapath_p.sv
// Testbench for bus_datapath_p (WIDTH=32, NREGS=16). A behavioural model tracks
// every register and the MUL/DIV timing; a negedge process compares all outputs
// with it each cycle, and directed checks pin literal expected values.
module tb_bus_datapath_p;
    localparam int W = 32;
    localparam int N = 16;

    logic          clk = 1'b0;
    logic          clr;
    logic [N-1:0]  reg_in, reg_out;
    logic          pc_in, pc_out, inc_pc, ir_in, y_in, mar_in, hi_in, lo_in;
    logic          hi_out, lo_out, zhi_out, zlo_out, mdr_out, c_out, z_in;
    logic          mdr_in, read, mem_rdy, alu_start;
    logic [W-1:0]  mdatain, c_value;
    logic [3:0]    alu_op;
    logic          alu_busy, alu_done, div0, mdr_wait, bus_err;
    logic [W-1:0]  bus, ir_q, mar_q, pc_q;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    bus_datapath_p #(.WIDTH(W), .NREGS(N), .SHW(5)) dut (
        .clk(clk), .clr(clr), .reg_in(reg_in), .reg_out(reg_out),
        .pc_in(pc_in), .pc_out(pc_out), .inc_pc(inc_pc), .ir_in(ir_in),
        .y_in(y_in), .mar_in(mar_in), .hi_in(hi_in), .lo_in(lo_in),
        .hi_out(hi_out), .lo_out(lo_out), .zhi_out(zhi_out), .zlo_out(zlo_out),
        .mdr_out(mdr_out), .c_out(c_out), .z_in(z_in), .mdr_in(mdr_in),
        .read(read), .mem_rdy(mem_rdy), .mdatain(mdatain), .c_value(c_value),
        .alu_op(alu_op), .alu_start(alu_start), .alu_busy(alu_busy),
        .alu_done(alu_done), .div0(div0), .mdr_wait(mdr_wait), .bus_err(bus_err),
        .bus(bus), .ir_q(ir_q), .mar_q(mar_q), .pc_q(pc_q)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [W-1:0] m_r [N];
    logic [W-1:0] m_pc, m_ir, m_y, m_mar, m_hi, m_lo, m_mdr, m_zhi, m_zlo;
    logic [W-1:0] p_hi, p_lo;
    bit           m_div0, m_done;
    int           m_left;

    function automatic int model_drivers();
        int c = 0;
        for (int i = 0; i < N; i++) if (reg_out[i]) c++;
        c += int'(pc_out) + int'(hi_out) + int'(lo_out) + int'(zhi_out) +
             int'(zlo_out) + int'(mdr_out) + int'(c_out);
        return c;
    endfunction

    function automatic logic [W-1:0] model_bus();
        logic [W-1:0] v = '0;
        for (int i = 0; i < N; i++) if (reg_out[i]) v = m_r[i];
        if (pc_out)  v = m_pc;
        if (hi_out)  v = m_hi;
        if (lo_out)  v = m_lo;
        if (zhi_out) v = m_zhi;
        if (zlo_out) v = m_zlo;
        if (mdr_out) v = m_mdr;
        if (c_out)   v = c_value;
        return (model_drivers() == 1) ? v : '0;
    endfunction

    function automatic logic [W-1:0] alu_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic [3:0] op);
        int sh;
        sh = int'(b[4:0]);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a >> sh;
            4'd5:    return $signed(a) >>> sh;
            4'd6:    return a << sh;
            4'd7:    return (a >> sh) | (a << (W - sh));
            4'd8:    return (a << sh) | (a >> (W - sh));
            4'd9:    return -b;
            4'd10:   return ~b;
            default: return '0;
        endcase
    endfunction

    always @(posedge clk or posedge clr) begin : model_upd
        logic [W-1:0] b, zres;
        bit           busy_now, old_done;
        int           sa, sb;
        longint       pr;
        if (clr) begin
            for (int i = 0; i < N; i++) m_r[i] = '0;
            m_pc = '0; m_ir = '0; m_y = '0; m_mar = '0; m_hi = '0; m_lo = '0;
            m_mdr = '0; m_zhi = '0; m_zlo = '0; m_div0 = 0; m_done = 0; m_left = 0;
        end else begin
            b        = model_bus();
            busy_now = (m_left > 0);
            zres     = alu_model(m_y, b, alu_op);
            old_done = m_done;
            m_done   = 0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_zhi = p_hi; m_zlo = p_lo; m_done = 1;
                end
            end else if (!old_done && alu_start && (alu_op == 4'd11 || alu_op == 4'd12)) begin
                sa = m_y; sb = b;
                if (alu_op == 4'd11) begin
                    pr = longint'(sa) * longint'(sb);
                    p_hi = pr[63:32]; p_lo = pr[31:0];
                end else begin
                    m_div0 = (b == '0);
                    if (b == '0) begin p_lo = '1; p_hi = m_y; end
                    else begin p_lo = sa / sb; p_hi = sa % sb; end
                end
                m_left = W;
            end
            if (z_in && !busy_now) begin m_zlo = zres; m_zhi = '0; end
            for (int i = 0; i < N; i++) if (reg_in[i]) m_r[i] = b;
            if (pc_in)       m_pc = b;
            else if (inc_pc) m_pc = m_pc + 32'd1;
            if (ir_in)  m_ir  = b;
            if (y_in)   m_y   = b;
            if (mar_in) m_mar = b;
            if (hi_in)  m_hi  = b;
            if (lo_in)  m_lo  = b;
            if (mdr_in) begin
                if (!read)        m_mdr = b;
                else if (mem_rdy) m_mdr = mdatain;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk ("model_bus",      bus,   model_bus());
            chk1("model_bus_err",  bus_err, model_drivers() > 1);
            chk1("model_mdr_wait", mdr_wait, mdr_in && read && !mem_rdy);
            chk ("model_pc",       pc_q,  m_pc);
            chk ("model_ir",       ir_q,  m_ir);
            chk ("model_mar",      mar_q, m_mar);
            chk1("model_busy",     alu_busy, m_left > 0);
            chk1("model_done",     alu_done, m_done);
            chk1("model_div0",     div0,  m_div0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        reg_in = '0; reg_out = '0;
        pc_in = 0; pc_out = 0; inc_pc = 0; ir_in = 0; y_in = 0; mar_in = 0;
        hi_in = 0; lo_in = 0; hi_out = 0; lo_out = 0; zhi_out = 0; zlo_out = 0;
        mdr_out = 0; c_out = 0; z_in = 0; mdr_in = 0; read = 0; mem_rdy = 0;
        alu_start = 0; alu_op = '0; c_value = '0; mdatain = '0;
    endtask

    task automatic set_reg(input int idx, input logic [W-1:0] v);
        c_value = v; c_out = 1; reg_in[idx] = 1;
        tick(); idle_in();
    endtask

    task automatic set_y(input logic [W-1:0] v);
        c_value = v; c_out = 1; y_in = 1;
        tick(); idle_in();
    endtask

    // Caller has set a drive strobe; check the bus then release it.
    task automatic look(input string name, input logic [W-1:0] exp);
        #1;
        chk(name, bus, exp);
        tick(); idle_in();
    endtask

    task automatic peek_reg(input string name, input int idx, input logic [W-1:0] exp);
        reg_out[idx] = 1;
        look(name, exp);
    endtask

    task automatic peek_z(input string name, input logic [W-1:0] ehi, input logic [W-1:0] elo);
        zhi_out = 1; look({name, "_zhi"}, ehi);
        zlo_out = 1; look({name, "_zlo"}, elo);
    endtask

    task automatic alu1(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] op, input logic [W-1:0] exp);
        set_y(a);
        c_value = b; c_out = 1; alu_op = op; z_in = 1;
        tick(); idle_in();
        peek_z(name, '0, exp);
    endtask

    // Start MUL/DIV and count ticks after the start edge until alu_done is seen.
    task automatic run_md(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op,
                          output int n);
        set_y(a);
        c_value = b; c_out = 1; alu_op = op; alu_start = 1;
        tick(); idle_in();
        n = 0;
        while (!alu_done && n < 40) begin tick(); n++; end
        chk1("md_timeout", alu_done, 1'b1);
    endtask

    int  n;
    bit  saw_done;

    initial begin
        idle_in();
        clr = 1;
        repeat (2) @(posedge clk);
        #1 clr = 0;
        chk_en = 1;
        chk ("reset_bus", bus, 32'h0);
        chk ("reset_pc", pc_q, 32'h0);
        chk1("reset_busy", alu_busy, 1'b0);
        peek_reg("reset_r0", 0, 32'h0);

        // Reset in the middle of a MUL aborts it.
        set_reg(3, 32'hAA);
        c_value = 32'h10; c_out = 1; pc_in = 1; tick(); idle_in();
        set_y(32'd3);
        c_value = 32'd5; c_out = 1; alu_op = 4'd11; alu_start = 1;
        tick(); idle_in();
        repeat (9) tick();
        chk1("mul_busy_before_clr", alu_busy, 1'b1);
        clr = 1;
        #1;
        chk1("clr_busy", alu_busy, 1'b0);
        chk1("clr_done", alu_done, 1'b0);
        chk ("clr_pc", pc_q, 32'h0);
        tick(); tick();
        clr = 0;
        saw_done = 0;
        for (int i = 0; i < 40; i++) begin
            if (alu_done) saw_done = 1;
            tick();
        end
        chk1("abort_no_done", saw_done, 1'b0);
        peek_z("abort", 32'h0, 32'h0);
        peek_reg("abort_r3", 3, 32'h0);

        // Basic transfer and AND.
        set_reg(2, 32'h12);
        set_reg(4, 32'h0F);
        reg_out[2] = 1; y_in = 1; tick(); idle_in();
        reg_out[4] = 1; alu_op = 4'd2; z_in = 1; tick(); idle_in();
        zlo_out = 1; reg_in[5] = 1; tick(); idle_in();
        peek_reg("and_r5", 5, 32'h2);
        reg_out[4] = 1; reg_in[4] = 1; tick(); idle_in();
        peek_reg("self_load_r4", 4, 32'h0F);

        // Single-cycle ALU ops.
        alu1("add_wrap", 32'hFFFF_FFFF, 32'd2, 4'd0, 32'h1);
        alu1("sub",      32'd5, 32'd7, 4'd1, 32'hFFFF_FFFE);
        alu1("or",       32'hF0, 32'h0F, 4'd3, 32'hFF);
        alu1("shr",      32'h8000_0001, 32'd31, 4'd4, 32'h1);
        alu1("shra",     32'h8000_0001, 32'd4, 4'd5, 32'hF800_0000);
        alu1("shl",      32'h0F, 32'd8, 4'd6, 32'hF00);
        alu1("ror",      32'h8000_0001, 32'd4, 4'd7, 32'h1800_0000);
        alu1("rol",      32'h8000_0001, 32'd4, 4'd8, 32'h18);
        alu1("neg",      32'd0, 32'd1, 4'd9, 32'hFFFF_FFFF);
        alu1("not",      32'd0, 32'd0, 4'd10, 32'hFFFF_FFFF);
        alu1("op13",     32'd5, 32'd3, 4'd13, 32'h0);

        // Bus contention.
        set_reg(1, 32'h55);
        set_reg(7, 32'h99);
        reg_out[1] = 1; pc_out = 1; reg_in[7] = 1;
        #1;
        chk ("contention_bus", bus, 32'h0);
        chk1("contention_err", bus_err, 1'b1);
        tick(); idle_in();
        peek_reg("contention_r7", 7, 32'h0);

        // MUL -7 * 6 with ignored start / z_in and bus traffic during RUN.
        set_y(32'hFFFF_FFF9);
        c_value = 32'd6; c_out = 1; alu_op = 4'd11; alu_start = 1;
        tick(); idle_in();
        n = 0;
        while (!alu_done && n < 40) begin
            if (n == 5)  begin alu_op = 4'd12; alu_start = 1; c_out = 1; c_value = 32'd3; end
            if (n == 10) begin alu_op = 4'd0; z_in = 1; c_out = 1; c_value = 32'd1; end
            if (n == 15) begin c_out = 1; c_value = 32'h77; reg_in[8] = 1; end
            tick(); idle_in();
            n++;
        end
        // Start requested in cycle c; done seen in cycle c+33, i.e. 32 edges after the start edge.
        chk("mul_latency", n, 32'd32);
        tick();
        chk1("mul_done_one_cycle", alu_done, 1'b0);
        peek_z("mul", 32'hFFFF_FFFF, 32'hFFFF_FFD6);
        peek_reg("run_traffic_r8", 8, 32'h77);

        // DIV cases.
        run_md(32'hFFFF_FFEF, 32'd5, 4'd12, n);
        chk("div_latency", n, 32'd32);
        chk1("div_div0_clear", div0, 1'b0);
        tick();
        peek_z("div", 32'hFFFF_FFFE, 32'hFFFF_FFFD);
        run_md(32'd9, 32'd0, 4'd12, n);
        chk1("div0_set", div0, 1'b1);
        tick();
        peek_z("div_by0", 32'd9, 32'hFFFF_FFFF);
        c_value = 32'd4; c_out = 1; alu_op = 4'd3; alu_start = 1;
        tick(); idle_in();
        chk1("start_bad_op_ignored", alu_busy, 1'b0);
        chk1("div0_holds", div0, 1'b1);

        // MDR wait states.
        c_value = 32'h1234; c_out = 1; mdr_in = 1; tick(); idle_in();
        for (int k = 0; k < 3; k++) begin
            mdr_in = 1; read = 1; mem_rdy = 0; mdatain = 32'hCAFE_0001; mdr_out = 1;
            #1;
            chk1("mdr_wait_high", mdr_wait, 1'b1);
            chk ("mdr_hold", bus, 32'h1234);
            tick(); idle_in();
        end
        mdr_in = 1; read = 1; mem_rdy = 1; mdatain = 32'hCAFE_0001;
        #1;
        chk1("mdr_wait_low", mdr_wait, 1'b0);
        tick(); idle_in();
        mdr_out = 1; look("mdr_loaded", 32'hCAFE_0001);

        // PC priority and wrap, IR/MAR, HI/LO.
        c_value = 32'h40; c_out = 1; pc_in = 1; inc_pc = 1; tick(); idle_in();
        chk("pc_in_priority", pc_q, 32'h40);
        inc_pc = 1; tick(); idle_in();
        chk("pc_inc", pc_q, 32'h41);
        c_value = 32'hFFFF_FFFF; c_out = 1; pc_in = 1; tick(); idle_in();
        inc_pc = 1; tick(); idle_in();
        chk("pc_wrap", pc_q, 32'h0);
        c_value = 32'hA5A5_0F0F; c_out = 1; mar_in = 1; ir_in = 1; tick(); idle_in();
        chk("mar_load", mar_q, 32'hA5A5_0F0F);
        chk("ir_load", ir_q, 32'hA5A5_0F0F);
        c_value = 32'h11; c_out = 1; hi_in = 1; tick(); idle_in();
        c_value = 32'h22; c_out = 1; lo_in = 1; tick(); idle_in();
        hi_out = 1; look("hi_load", 32'h11);
        lo_out = 1; look("lo_load", 32'h22);

        tick();
        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
